// File: rtl/bp_be_pkg.sv
// Shared definitions for the backend issue scheduler: pipe one-hot layout,
// scheduler FSM states and default pipe latencies.
package bp_be_pkg;

  localparam int pipe_width_lp    = 6;
  localparam int pipe_ctrl_bit_lp = 0;
  localparam int pipe_int_bit_lp  = 1;
  localparam int pipe_mem_bit_lp  = 2;
  localparam int pipe_mul_bit_lp  = 3;
  localparam int pipe_fp_bit_lp   = 4;
  localparam int pipe_long_bit_lp = 5;

  localparam int int_lat_lp      = 0;
  localparam int mul_lat_lp      = 2;
  localparam int mem_lat_lp      = 2;
  localparam int drain_cycles_lp = 4;

  typedef enum logic [1:0] {
    e_sched_ready = 2'd0,
    e_sched_drain = 2'd1,
    e_sched_wait  = 2'd2
  } sched_state_e;

  // Counter width able to hold max_val, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bp_be_scoreboard.sv
// Per-register countdown scoreboard plus long-latency pending vector, with
// combinational hazard queries for the held instruction's rs1, rs2 and rd.
module bp_be_scoreboard
  import bp_be_pkg::*;
#(
  parameter int reg_addr_width_p = 5,
  parameter int int_lat_p        = int_lat_lp,
  parameter int mul_lat_p        = mul_lat_lp,
  parameter int mem_lat_p        = mem_lat_lp
)
(
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        flush_i,
  input  logic                        set_v_i,
  input  logic [reg_addr_width_p-1:0] set_rd_i,
  input  logic [pipe_width_lp-1:0]    set_pipe_i,
  input  logic                        long_wb_v_i,
  input  logic [reg_addr_width_p-1:0] long_wb_rd_i,
  input  logic [reg_addr_width_p-1:0] rs1_i,
  input  logic [reg_addr_width_p-1:0] rs2_i,
  input  logic [reg_addr_width_p-1:0] rd_i,
  output logic                        rs1_busy_o,
  output logic                        rs2_busy_o,
  output logic                        rd_pend_o,
  output logic                        long_busy_o,
  output logic                        all_clear_o
);

  localparam int num_regs_lp = 1 << reg_addr_width_p;
  localparam int max_lat_lp  = (int_lat_p > mul_lat_p)
                             ? ((int_lat_p > mem_lat_p) ? int_lat_p : mem_lat_p)
                             : ((mul_lat_p > mem_lat_p) ? mul_lat_p : mem_lat_p);
  localparam int cnt_w_lp    = cnt_width(max_lat_lp);

  typedef logic [cnt_w_lp-1:0]         cnt_t;
  typedef logic [reg_addr_width_p-1:0] addr_t;

  cnt_t                   r_cnt [num_regs_lp];
  logic [num_regs_lp-1:0] r_pend;
  logic                   r_long_busy;

  cnt_t w_set_lat;
  logic w_set_cnt;
  logic w_set_long;
  logic w_any_cnt;

  // x0 is never marked; fp results do not land in the integer file.
  always_comb begin
    w_set_lat  = '0;
    w_set_cnt  = 1'b0;
    w_set_long = 1'b0;
    if (set_v_i && (set_rd_i != '0)) begin
      if (set_pipe_i[pipe_long_bit_lp]) begin
        w_set_long = 1'b1;
      end else if (set_pipe_i[pipe_mul_bit_lp]) begin
        w_set_cnt = 1'b1;
        w_set_lat = cnt_t'(mul_lat_p);
      end else if (set_pipe_i[pipe_mem_bit_lp]) begin
        w_set_cnt = 1'b1;
        w_set_lat = cnt_t'(mem_lat_p);
      end else if (set_pipe_i[pipe_fp_bit_lp]) begin
        w_set_cnt = 1'b0;
      end else if (set_pipe_i[pipe_int_bit_lp] || set_pipe_i[pipe_ctrl_bit_lp]) begin
        w_set_cnt = 1'b1;
        w_set_lat = cnt_t'(int_lat_p);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_regs_lp; i++) r_cnt[i] <= '0;
      r_pend      <= '0;
      r_long_busy <= 1'b0;
    end else begin
      for (int i = 0; i < num_regs_lp; i++) begin
        if (flush_i)
          r_cnt[i] <= '0;
        else if (w_set_cnt && (set_rd_i == addr_t'(i)))
          r_cnt[i] <= w_set_lat;
        else if (r_cnt[i] != '0)
          r_cnt[i] <= r_cnt[i] - cnt_t'(1);
      end
      // A long issue in the same cycle as a write-back wins over the clear.
      if (long_wb_v_i) begin
        r_pend[long_wb_rd_i] <= 1'b0;
        r_long_busy          <= 1'b0;
      end
      if (w_set_long) begin
        r_pend[set_rd_i] <= 1'b1;
        r_long_busy      <= 1'b1;
      end
    end
  end

  always_comb begin
    w_any_cnt = 1'b0;
    for (int i = 0; i < num_regs_lp; i++) w_any_cnt = w_any_cnt | (r_cnt[i] != '0);
  end

  assign rs1_busy_o  = (rs1_i != '0) && ((r_cnt[rs1_i] != '0) || r_pend[rs1_i]);
  assign rs2_busy_o  = (rs2_i != '0) && ((r_cnt[rs2_i] != '0) || r_pend[rs2_i]);
  assign rd_pend_o   = (rd_i != '0) && r_pend[rd_i];
  assign long_busy_o = r_long_busy;
  assign all_clear_o = ~w_any_cnt & ~(|r_pend);

endmodule

// File: rtl/bp_be_issue_scheduler.sv
// Single-entry issue register with RAW/WAW, structural and serialization
// hazard checks; serializing ops drain the pipe, issue, then block until done.
module bp_be_issue_scheduler
  import bp_be_pkg::*;
#(
  parameter int reg_addr_width_p = 5,
  parameter int int_lat_p        = int_lat_lp,
  parameter int mul_lat_p        = mul_lat_lp,
  parameter int mem_lat_p        = mem_lat_lp,
  parameter int drain_cycles_p   = drain_cycles_lp
)
(
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        dispatch_v_i,
  output logic                        dispatch_ready_o,
  input  logic [reg_addr_width_p-1:0] rs1_i,
  input  logic [reg_addr_width_p-1:0] rs2_i,
  input  logic [reg_addr_width_p-1:0] rd_i,
  input  logic                        rs1_v_i,
  input  logic                        rs2_v_i,
  input  logic                        irf_w_v_i,
  input  logic [pipe_width_lp-1:0]    pipe_i,
  input  logic                        serial_v_i,
  input  logic                        issue_ready_i,
  output logic                        issue_v_o,
  output logic [pipe_width_lp-1:0]    issue_pipe_o,
  output logic [reg_addr_width_p-1:0] issue_rd_o,
  input  logic                        long_wb_v_i,
  input  logic [reg_addr_width_p-1:0] long_wb_rd_i,
  input  logic                        serial_done_i,
  input  logic                        flush_i,
  output sched_state_e                dbg_state_o
);

  localparam int drain_w_lp = cnt_width(drain_cycles_p);
  typedef logic [drain_w_lp-1:0] drain_t;

  logic                        r_held_v;
  logic [reg_addr_width_p-1:0] r_rs1, r_rs2, r_rd;
  logic                        r_rs1_v, r_rs2_v, r_irf_w_v, r_serial;
  logic [pipe_width_lp-1:0]    r_pipe;
  drain_t                      r_drain_cnt;
  sched_state_e                r_state, w_state_n;

  logic w_rs1_busy, w_rs2_busy, w_rd_pend, w_long_busy, w_all_clear;
  logic w_hazard, w_permit, w_issue_fire, w_accept;

  bp_be_scoreboard #(
    .reg_addr_width_p(reg_addr_width_p),
    .int_lat_p       (int_lat_p),
    .mul_lat_p       (mul_lat_p),
    .mem_lat_p       (mem_lat_p)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .flush_i     (flush_i),
    .set_v_i     (w_issue_fire & r_irf_w_v),
    .set_rd_i    (r_rd),
    .set_pipe_i  (r_pipe),
    .long_wb_v_i (long_wb_v_i),
    .long_wb_rd_i(long_wb_rd_i),
    .rs1_i       (r_rs1),
    .rs2_i       (r_rs2),
    .rd_i        (r_rd),
    .rs1_busy_o  (w_rs1_busy),
    .rs2_busy_o  (w_rs2_busy),
    .rd_pend_o   (w_rd_pend),
    .long_busy_o (w_long_busy),
    .all_clear_o (w_all_clear)
  );

  // Hazards use pre-update scoreboard state: no same-cycle write-back bypass.
  assign w_hazard = (r_rs1_v & w_rs1_busy) | (r_rs2_v & w_rs2_busy)
                  | (r_irf_w_v & w_rd_pend)
                  | (r_pipe[pipe_long_bit_lp] & w_long_busy);

  always_comb begin
    w_state_n = r_state;
    w_permit  = 1'b0;
    case (r_state)
      e_sched_ready: begin
        w_permit = ~r_serial;
        if (!flush_i && r_held_v && r_serial) w_state_n = e_sched_drain;
      end
      e_sched_drain: begin
        w_permit = (r_drain_cnt == '0) & w_all_clear;
        if (flush_i)           w_state_n = e_sched_ready;
        else if (w_issue_fire) w_state_n = e_sched_wait;
      end
      e_sched_wait: begin
        if (serial_done_i) w_state_n = e_sched_ready;
      end
      default: w_state_n = e_sched_ready;
    endcase
  end

  assign w_issue_fire = r_held_v & ~w_hazard & issue_ready_i & ~flush_i & w_permit;

  // Handshake: an instruction transfers on the posedge where dispatch_v_i and
  // dispatch_ready_o are both high; ready never depends on dispatch_v_i.
  assign dispatch_ready_o = (~r_held_v | w_issue_fire) & ~flush_i & (r_state != e_sched_wait);
  assign w_accept         = dispatch_v_i & dispatch_ready_o;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state     <= e_sched_ready;
      r_held_v    <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_rs1_v     <= 1'b0;
      r_rs2_v     <= 1'b0;
      r_irf_w_v   <= 1'b0;
      r_serial    <= 1'b0;
      r_pipe      <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_state <= w_state_n;
      if (flush_i) begin
        r_held_v <= 1'b0;
      end else if (w_accept) begin
        r_held_v  <= 1'b1;
        r_rs1     <= rs1_i;
        r_rs2     <= rs2_i;
        r_rd      <= rd_i;
        r_rs1_v   <= rs1_v_i;
        r_rs2_v   <= rs2_v_i;
        r_irf_w_v <= irf_w_v_i;
        r_serial  <= serial_v_i;
        r_pipe    <= pipe_i;
      end else if (w_issue_fire) begin
        r_held_v <= 1'b0;
      end
      if (w_issue_fire)
        r_drain_cnt <= drain_t'(drain_cycles_p);
      else if (r_drain_cnt != '0)
        r_drain_cnt <= r_drain_cnt - drain_t'(1);
    end
  end

  assign issue_v_o    = w_issue_fire;
  assign issue_pipe_o = r_pipe;
  assign issue_rd_o   = r_rd;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_bp_be_issue_scheduler.sv
// Randomized bench for bp_be_issue_scheduler: a cycle-based reference model
// predicts issues, readiness and scheduler phase; a monitor scores the DUT.
`timescale 1ns/1ps
module tb_bp_be_issue_scheduler;
  import bp_be_pkg::*;

  localparam int N_CYCLES = 4000;
  localparam int D_LAT    = drain_cycles_lp;
  localparam int EW       = 32 + 6 + 5;
  localparam int CW       = 32 + 1 + 2;

  logic         clk = 1'b0;
  logic         reset_n_i = 1'b0;
  logic         dispatch_v_i = 1'b0;
  logic         dispatch_ready_o;
  logic [4:0]   rs1_i = '0, rs2_i = '0, rd_i = '0;
  logic         rs1_v_i = 1'b0, rs2_v_i = 1'b0, irf_w_v_i = 1'b0;
  logic [5:0]   pipe_i = '0;
  logic         serial_v_i = 1'b0;
  logic         issue_ready_i = 1'b0;
  logic         issue_v_o;
  logic [5:0]   issue_pipe_o;
  logic [4:0]   issue_rd_o;
  logic         long_wb_v_i = 1'b0;
  logic [4:0]   long_wb_rd_i = '0;
  logic         serial_done_i = 1'b0;
  logic         flush_i = 1'b0;
  sched_state_e dbg_state_o;

  bp_be_issue_scheduler dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n_i),
    .dispatch_v_i    (dispatch_v_i),
    .dispatch_ready_o(dispatch_ready_o),
    .rs1_i           (rs1_i),
    .rs2_i           (rs2_i),
    .rd_i            (rd_i),
    .rs1_v_i         (rs1_v_i),
    .rs2_v_i         (rs2_v_i),
    .irf_w_v_i       (irf_w_v_i),
    .pipe_i          (pipe_i),
    .serial_v_i      (serial_v_i),
    .issue_ready_i   (issue_ready_i),
    .issue_v_o       (issue_v_o),
    .issue_pipe_o    (issue_pipe_o),
    .issue_rd_o      (issue_rd_o),
    .long_wb_v_i     (long_wb_v_i),
    .long_wb_rd_i    (long_wb_rd_i),
    .serial_done_i   (serial_done_i),
    .flush_i         (flush_i),
    .dbg_state_o     (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [CW-1:0] ctl_q[$];

  // ---------------- reference model ----------------
  // A register is readable from cycle ready_at[r] on; pend/lbusy track the
  // single long op; serial ops go draining -> in_flight -> done.
  int   m_cyc = 0;
  int   ready_at [32];
  bit   pend [32];
  bit   lbusy, draining, in_flight;
  int   last_issue;
  bit   h_v, h_rs1v, h_rs2v, h_w, h_serial;
  logic [4:0] h_rs1, h_rs2, h_rd;
  logic [5:0] h_pipe;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      ready_at[r] = 0;
      pend[r]     = 1'b0;
    end
    lbusy = 1'b0; draining = 1'b0; in_flight = 1'b0;
    last_issue = -1000;
    h_v = 1'b0;
  endtask

  function automatic bit src_blocked(input bit v, input logic [4:0] r);
    return v && (r != 5'd0) && ((m_cyc < ready_at[r]) || pend[r]);
  endfunction

  function automatic bit pipe_empty();
    bit e;
    e = (m_cyc >= last_issue + D_LAT + 1);
    for (int r = 0; r < 32; r++) if (ready_at[r] > m_cyc || pend[r]) e = 1'b0;
    return e;
  endfunction

  function automatic int lat_of(input logic [5:0] p);
    if (p[pipe_mul_bit_lp]) return mul_lat_lp;
    if (p[pipe_mem_bit_lp]) return mem_lat_lp;
    if (p[pipe_int_bit_lp] || p[pipe_ctrl_bit_lp]) return int_lat_lp;
    return -1;
  endfunction

  // ---------------- driver ----------------
  initial begin
    int  rst_left;
    bit  did_mid_reset;
    bit  permit, haz, fire, rdy, accept;
    int  lat, k;
    sched_state_e exp_state;

    model_reset();
    rst_left = 3;
    did_mid_reset = 1'b0;
    for (int i = 0; i < N_CYCLES; i++) begin
      @(negedge clk);
      if (!did_mid_reset && i >= 2000 && (in_flight || i >= 2400)) begin
        did_mid_reset = 1'b1;
        rst_left = 2;
      end
      if (rst_left > 0) begin
        rst_left--;
        reset_n_i = 1'b0;
        dispatch_v_i = 1'b0; issue_ready_i = 1'b0; flush_i = 1'b0;
        long_wb_v_i = 1'b0; serial_done_i = 1'b0;
        model_reset();
        m_cyc++;
        continue;
      end
      reset_n_i = 1'b1;

      dispatch_v_i = ($urandom_range(0, 3) != 0);
      rs1_i     = 5'($urandom_range(0, 7));
      rs2_i     = 5'($urandom_range(0, 7));
      rd_i      = 5'($urandom_range(0, 7));
      rs1_v_i   = ($urandom_range(0, 3) != 0);
      rs2_v_i   = ($urandom_range(0, 1) != 0);
      irf_w_v_i = ($urandom_range(0, 3) != 0);
      serial_v_i = ($urandom_range(0, 9) == 0);
      pipe_i    = serial_v_i ? 6'b000001 : (6'b000001 << $urandom_range(0, 5));
      issue_ready_i = ($urandom_range(0, 7) != 0);
      flush_i   = ($urandom_range(0, 39) == 0);
      serial_done_i = in_flight && ($urandom_range(0, 3) == 0);
      long_wb_v_i = 1'b0;
      long_wb_rd_i = 5'($urandom_range(0, 31));
      if (lbusy && $urandom_range(0, 4) == 0) begin
        for (int r = 1; r < 32; r++) if (pend[r]) long_wb_rd_i = 5'(r);
        long_wb_v_i = 1'b1;
      end

      // predictions for this cycle from pre-edge model state
      if (in_flight)     permit = 1'b0;
      else if (h_serial) permit = draining && pipe_empty();
      else               permit = !draining;
      haz = src_blocked(h_rs1v, h_rs1) || src_blocked(h_rs2v, h_rs2)
         || (h_w && h_rd != 5'd0 && pend[h_rd])
         || (h_pipe[pipe_long_bit_lp] && lbusy);
      fire = h_v && permit && !haz && issue_ready_i && !flush_i;
      rdy  = (!h_v || fire) && !flush_i && !in_flight;
      exp_state = in_flight ? e_sched_wait : (draining ? e_sched_drain : e_sched_ready);
      ctl_q.push_back({32'(m_cyc), rdy, exp_state});
      if (fire) exp_q.push_back({32'(m_cyc), h_pipe, h_rd});

      // model update at the edge
      if (flush_i) for (int r = 0; r < 32; r++) ready_at[r] = 0;
      if (long_wb_v_i) begin
        pend[long_wb_rd_i] = 1'b0;
        lbusy = 1'b0;
      end
      if (fire && h_w && h_rd != 5'd0) begin
        if (h_pipe[pipe_long_bit_lp]) begin
          pend[h_rd] = 1'b1;
          lbusy = 1'b1;
        end else begin
          lat = lat_of(h_pipe);
          if (lat >= 0) ready_at[h_rd] = m_cyc + 1 + lat;
        end
      end
      if (fire) last_issue = m_cyc;
      if (fire && h_serial) begin
        in_flight = 1'b1;
        draining  = 1'b0;
      end else if (in_flight && serial_done_i) begin
        in_flight = 1'b0;
      end else if (flush_i) begin
        draining = 1'b0;
      end else if (h_v && h_serial && !in_flight) begin
        draining = 1'b1;
      end
      accept = dispatch_v_i && rdy;
      if (flush_i) h_v = 1'b0;
      else if (accept) begin
        h_v = 1'b1; h_rs1 = rs1_i; h_rs2 = rs2_i; h_rd = rd_i;
        h_rs1v = rs1_v_i; h_rs2v = rs2_v_i; h_w = irf_w_v_i;
        h_serial = serial_v_i; h_pipe = pipe_i;
      end else if (fire) h_v = 1'b0;
      m_cyc++;
    end

    @(negedge clk);
    dispatch_v_i = 1'b0; issue_ready_i = 1'b0;
    #4;
    k = exp_q.size();
    checks++;
    if (k != 0) begin
      errors++;
      $display("FAIL leftover_issues got %0d pending expected 0", k);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- monitor ----------------
  initial begin
    int mon_cyc;
    logic [CW-1:0] c;
    logic [EW-1:0] e, got;
    mon_cyc = 0;
    forever begin
      @(negedge clk);
      #2;
      if (ctl_q.size() != 0 && ctl_q[0][CW-1 -: 32] == 32'(mon_cyc)) begin
        c = ctl_q.pop_front();
        checks++;
        if (dispatch_ready_o !== c[2]) begin
          errors++;
          $display("FAIL dispatch_ready cyc %0d got %b expected %b", mon_cyc, dispatch_ready_o, c[2]);
        end
        checks++;
        if (dbg_state_o !== sched_state_e'(c[1:0])) begin
          errors++;
          $display("FAIL sched_state cyc %0d got %0d expected %0d", mon_cyc, dbg_state_o, c[1:0]);
        end
      end
      if (issue_v_o === 1'b1) begin
        checks++;
        got = {32'(mon_cyc), issue_pipe_o, issue_rd_o};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL issue_unexpected cyc %0d got pipe %b rd %0d expected no issue",
                   mon_cyc, issue_pipe_o, issue_rd_o);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL issue cyc %0d got pipe %b rd %0d expected cyc %0d pipe %b rd %0d",
                     mon_cyc, issue_pipe_o, issue_rd_o, e[EW-1 -: 32], e[9:4], e[4:0]);
          end
        end
      end else if (issue_v_o !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL issue_v_unknown cyc %0d got %b expected 0 or 1", mon_cyc, issue_v_o);
      end else if (exp_q.size() != 0 && exp_q[0][EW-1 -: 32] <= 32'(mon_cyc)) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL issue_missed cyc %0d got none expected pipe %b rd %0d",
                 mon_cyc, e[10:5], e[4:0]);
      end
      mon_cyc++;
    end
  end

endmodule
